acc_burst_arbiter: RTL and testbench



---
 rtl/acc_burst_arbiter.sv | 147 ++++++++++++++
 tb/tb_acc_burst_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_burst_arbiter.sv
// Round-robin burst arbiter sequencing a shared unsigned up-accumulator.
// Optional build macro ACC_BURST_SAT_EN: saturating adds with sticky res_ovf.
module acc_burst_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int AW   = 8,
  parameter int LENW = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] req_len,
  input  logic [NREQ-1:0]      op_valid,
  input  logic [NREQ*DW-1:0]   op_data,
  output logic [NREQ-1:0]      op_ready,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 res_valid,
  output logic [AW-1:0]        res_data,
  output logic [IW-1:0]        res_id,
  output logic                 res_ovf,
  input  logic                 res_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [LENW-1:0] cnt;
  logic [IW-1:0]   last;

  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   scan_idx;
  logic [LENW-1:0] sel_len;
  logic [DW-1:0]   beat_data;
  logic            beat_valid;
  logic            beat;
  logic [AW-1:0]   acc_next;
  logic            ovf_next;

  // Round-robin pick: first set request after the last served index, with wrap.
  // NOTE: combinational blocks use blocking assignments and give every output a
  // default first, so scratch variables like scan_idx never infer latches.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = last;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = (scan_idx == IW'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!sel_found && req[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == IW'(i)) sel_len = req_len[i*LENW +: LENW];
    end
  end

  // The one-hot grant doubles as the operand mux select.
  always_comb begin
    beat_data  = '0;
    beat_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        beat_data  = op_data[i*DW +: DW];
        beat_valid = op_valid[i];
      end
    end
  end

  assign beat = beat_valid && (state == RUN);

`ifdef ACC_BURST_SAT_EN
  logic [AW:0] sum;
  assign sum      = {1'b0, acc} + {{(AW + 1 - DW){1'b0}}, beat_data};
  assign acc_next = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
  assign ovf_next = res_ovf | sum[AW];
`else
  assign acc_next = acc + {{(AW - DW){1'b0}}, beat_data};
  assign ovf_next = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_ovf   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      last      <= IW'(NREQ - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_found) begin
            gnt     <= NREQ'(1) << sel_idx;
            res_id  <= sel_idx;
            acc     <= '0;
            res_ovf <= 1'b0;
            cnt     <= sel_len;
            if (sel_len == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (beat) begin
            acc     <= acc_next;
            res_ovf <= ovf_next;
            cnt     <= cnt - 1'b1;
            if (cnt == LENW'(1)) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            gnt       <= '0;
            last      <= res_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign op_ready = (state == RUN) ? gnt : '0;
  assign busy     = (state != IDLE);
  assign res_data = acc;

endmodule

// File: tb/tb_acc_burst_arbiter.sv
// Directed self-checking bench for acc_burst_arbiter (built with DW=8 so one
// short burst can overflow the 8-bit accumulator).
module tb_acc_burst_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int LENW = 4;
  localparam int IW   = 2;

  logic                 clk = 1'b0;
  logic                 clear;
  logic [NREQ-1:0]      req;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ-1:0]      op_valid;
  logic [NREQ*DW-1:0]   op_data;
  logic [NREQ-1:0]      op_ready;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 res_valid;
  logic [AW-1:0]        res_data;
  logic [IW-1:0]        res_id;
  logic                 res_ovf;
  logic                 res_ready;

  int checks = 0;
  int errors = 0;

  acc_burst_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .LENW(LENW)) dut (
    .clk       (clk),
    .clear     (clear),
    .req       (req),
    .req_len   (req_len),
    .op_valid  (op_valid),
    .op_data   (op_data),
    .op_ready  (op_ready),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ovf   (res_ovf),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_len(input int i, input logic [LENW-1:0] v);
    req_len[i*LENW +: LENW] = v;
  endtask

  task automatic set_op(input int i, input logic v, input logic [DW-1:0] d);
    op_valid[i]          = v;
    op_data[i*DW +: DW]  = d;
  endtask

  task automatic wait_gnt(input string tag, input int exp_id);
    for (int n = 0; n < 20 && gnt == '0; n++) @(negedge clk);
    check(tag, 32'(gnt), 32'(1) << exp_id);
  endtask

  task automatic wait_res(input string tag, input int exp_data, input int exp_id);
    for (int n = 0; n < 20 && !res_valid; n++) @(negedge clk);
    check({tag, "_valid"}, 32'(res_valid), 1);
    check({tag, "_data"}, 32'(res_data), exp_data);
    check({tag, "_id"}, 32'(res_id), exp_id);
  endtask

  initial begin
    int exp_sum;
    int exp_ovf;
`ifdef ACC_BURST_SAT_EN
    exp_sum = 255;
    exp_ovf = 1;
`else
    exp_sum = (200 + 100 + 10) % 256;
    exp_ovf = 0;
`endif

    // Reset and idle
    clear = 1'b1; req = '0; req_len = '0; op_valid = '0; op_data = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_op_ready", 32'(op_ready), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_res_id", 32'(res_id), 0);
    check("rst_res_ovf", 32'(res_ovf), 0);
    clear = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_gnt", 32'(gnt), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_res_valid", 32'(res_valid), 0);
      check("idle_op_ready", 32'(op_ready), 0);
    end

    // Single burst: 5 + 7 + 9 on requester 0
    req = 4'b0001; set_len(0, 3); set_op(0, 1'b1, 8'd5); res_ready = 1'b1;
    @(negedge clk);
    check("single_gnt", 32'(gnt), 1);
    check("single_op_ready", 32'(op_ready), 1);
    check("single_busy", 32'(busy), 1);
    check("single_no_res", 32'(res_valid), 0);
    req = '0;
    @(negedge clk);
    set_op(0, 1'b1, 8'd7);
    @(negedge clk);
    set_op(0, 1'b1, 8'd9);
    @(negedge clk);
    set_op(0, 1'b0, 8'd0);
    check("single_valid", 32'(res_valid), 1);
    check("single_data", 32'(res_data), 21);
    check("single_id", 32'(res_id), 0);
    check("single_ovf", 32'(res_ovf), 0);
    check("single_done_op_ready", 32'(op_ready), 0);
    @(negedge clk);
    check("single_res_drop", 32'(res_valid), 0);
    check("single_gnt_drop", 32'(gnt), 0);
    check("single_idle", 32'(busy), 0);
    check("single_data_held", 32'(res_data), 21);

    // Round-robin fairness after reset: order 0,1,2,3,0
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      set_len(i, 1);
      set_op(i, 1'b1, 8'd1);
    end
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr_gnt", k % NREQ);
      if (k == 4) req = '0;
      wait_res("rr_res", 1, k % NREQ);
      @(negedge clk);
    end
    op_valid = '0; op_data = '0; req_len = '0;

    // Stalls and backpressure on requester 2 (last = 0)
    req = 4'b0100; set_len(2, 2); res_ready = 1'b0;
    @(negedge clk);
    check("stall_gnt", 32'(gnt), 4);
    check("stall_op_ready", 32'(op_ready), 4);
    req = '0;
    set_op(2, 1'b1, 8'd3);
    @(negedge clk);
    check("stall_acc1", 32'(res_data), 3);
    set_op(2, 1'b0, 8'hEE);
    set_op(0, 1'b1, 8'hFF); set_op(1, 1'b1, 8'hFF); set_op(3, 1'b1, 8'hFF);
    @(negedge clk);
    check("stall_op_ready_hold", 32'(op_ready), 4);
    check("stall_no_res1", 32'(res_valid), 0);
    @(negedge clk);
    check("stall_no_res2", 32'(res_valid), 0);
    check("stall_acc_hold", 32'(res_data), 3);
    op_valid = '0; op_data = '0;
    set_op(2, 1'b1, 8'd4);
    @(negedge clk);
    op_valid = '0;
    for (int j = 0; j < 3; j++) begin
      check("bp_valid", 32'(res_valid), 1);
      check("bp_data", 32'(res_data), 7);
      check("bp_id", 32'(res_id), 2);
      if (j < 2) @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_res_drop", 32'(res_valid), 0);
    check("bp_data_held", 32'(res_data), 7);
    check("bp_gnt_drop", 32'(gnt), 0);

    // Overflow on requester 1 (last = 2): 200 + 100 + 10
    req = 4'b0010; set_len(1, 3); set_op(1, 1'b1, 8'd200);
    @(negedge clk);
    check("ovf_gnt", 32'(gnt), 2);
    req = '0;
    @(negedge clk);
    set_op(1, 1'b1, 8'd100);
    @(negedge clk);
    set_op(1, 1'b1, 8'd10);
    @(negedge clk);
    set_op(1, 1'b0, 8'd0);
    check("ovf_valid", 32'(res_valid), 1);
    check("ovf_data", 32'(res_data), exp_sum);
    check("ovf_flag", 32'(res_ovf), exp_ovf);
    check("ovf_id", 32'(res_id), 1);
    @(negedge clk);
    check("ovf_res_drop", 32'(res_valid), 0);
    check("ovf_flag_held", 32'(res_ovf), exp_ovf);
    op_data = '0; req_len = '0;

    // Clear during the second beat of a 4-beat burst on requester 0
    req = 4'b0001; set_len(0, 4); set_op(0, 1'b1, 8'd1);
    @(negedge clk);
    check("mid_gnt", 32'(gnt), 1);
    req = '0;
    @(negedge clk);
    check("mid_acc1", 32'(res_data), 1);
    clear = 1'b1;
    @(negedge clk);
    check("mid_busy", 32'(busy), 0);
    check("mid_gnt_clr", 32'(gnt), 0);
    check("mid_op_ready", 32'(op_ready), 0);
    check("mid_res_valid", 32'(res_valid), 0);
    check("mid_res_data", 32'(res_data), 0);
    clear = 1'b0; op_valid = '0; op_data = '0; req_len = '0;
    req = 4'b1000; set_len(3, 0);
    @(negedge clk);
    req = '0;
    check("zero_gnt", 32'(gnt), 8);
    check("zero_valid", 32'(res_valid), 1);
    check("zero_data", 32'(res_data), 0);
    check("zero_id", 32'(res_id), 3);
    check("zero_op_ready", 32'(op_ready), 0);
    @(negedge clk);
    check("zero_res_drop", 32'(res_valid), 0);
    check("zero_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
